itch_order_encoder: RTL and testbench
=====================================

Name: itch_order_encoder

Overview:
- Parametrised successor to the fixed 9-register quote-to-order formatter.
- Accepts one quote per valid/ready handshake and serialises it into ITCH "A" (Add Order) messages, buy then sell, on a word-wide stream with valid/ready/last.
- Order reference numbers advance per emitted message, not per clock.
- Sits between the quote pricer and the outbound packet builder.

Parameters:
REG_WIDTH, 32, output word width; legal values 32 or 64; BPW = REG_WIDTH/8 bytes per word
ORDER_ID_W, 64, order reference counter width (1..64), zero-extended into the 8-byte field
ORDER_ID_BASE, 1, counter value after reset
TS_INC, 1, internal timestamp increment per cycle (used only with ENCODER_INT_TS_EN)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  quote valid
o_ready  out  1  quote accepted when i_valid && o_ready at i_clk rise
i_stock_symbol  in  2  0 AAPL, 1 AMZN, 2 GOOGL, 3 MSFT
i_side_en  in  2  bit0 emit buy, bit1 emit sell
i_buy_price  in  32  buy price
i_sell_price  in  32  sell price
i_quantity  in  32  shares
i_locate_code  in  16  stock locate
i_tracking_number  in  16  tracking number
i_timestamp  in  48  ns timestamp
i_flush  in  1  abort pending second message
o_data  out  REG_WIDTH  message word
o_valid  out  1  o_data valid
o_last  out  1  final word of a message
i_ready  in  1  downstream accepts word when o_valid && i_ready

Behaviour:
- Reset (async assert, sync release): state IDLE; o_valid=0, o_last=0, o_data=0; order counter=ORDER_ID_BASE; all capture registers 0.
- o_ready = (state==IDLE), combinational.
- Acceptance: all inputs captured in one cycle; the timestamp is captured at acceptance. If i_side_en==0, the quote is consumed with no output and the state stays IDLE. Otherwise go to EMIT_BUY when bit0 is set, else EMIT_SELL.
- First word has o_valid=1 in the cycle after acceptance. There are no idle bubbles while i_ready=1.
- Message: 36 bytes b0..b35.
  - b0=0x41.
  - b1-2 locate, b3-4 tracking, b5-10 timestamp, b11-18 order ref, b19 side (0x42 'B' / 0x53 'S'), b20-23 shares, b24-31 stock ASCII (b24 first char, space 0x20 padded), b32-35 price (buy or sell per side).
  - Multi-byte fields are big-endian (lowest byte index = MSB).
- Packing: word k bits [8j+7:8j] = b[k*BPW+j]. Bytes past 35 are 0. NUM_WORDS = ceil(36/BPW): 9 for 32-bit, 5 for 64-bit.
- A word index counter runs 0..NUM_WORDS-1 and advances on o_valid && i_ready. o_last=1 on the final index. o_data, o_valid and o_last are held stable while o_valid && !i_ready.
- On the last-word handshake, the order counter increments by 1, wrapping modulo 2^ORDER_ID_W. Then:
  - EMIT_BUY goes to EMIT_SELL if sell is enabled and no flush is pending; otherwise it goes to IDLE.
  - EMIT_SELL goes to IDLE.
- Sell message uses the incremented order ref.
- i_flush:
  - In IDLE: no effect.
  - In EMIT_BUY: latched as pending. The buy message completes intact, then the FSM goes to IDLE and skips sell.
  - In EMIT_SELL: sell completes intact.
  - Pending flush clears on entry to IDLE.
  - A message is never truncated.
- Returning to IDLE drops o_valid in the same edge as the last handshake; o_ready=1 in the next cycle. A new quote can be accepted then, giving one bubble between quotes.
- Async reset mid-message: output drops immediately, the partial message is discarded, and the counter returns to ORDER_ID_BASE.

Optional Feature:
- ENCODER_INT_TS_EN defined: an internal 48-bit free-running timestamp (reset 0, +TS_INC per cycle, wraps at 2^48) is captured at acceptance instead of i_timestamp. i_timestamp is ignored.
- Undefined: i_timestamp is used; no counter is built.

Test Plan:
1. REG_WIDTH=32; quote locate=0x0001, tracking=0x0002, ts=0x000000001234, symbol=0, side_en=3, qty=100, buy=0x2710, sell=0x2774, i_ready=1 -> 18 words, o_last on words 8 and 17. Buy word0=0x00010041, word4 byte19 field=0x42, order refs 1 then 2. Sell word8=0x74270000 (b32-35 price 0x00002774).
2. Hold i_ready=0 for 3 cycles at word 4 -> o_data/o_valid unchanged; the sequence resumes at word 4 with no words lost or duplicated.
3. side_en=0 -> o_ready stays 1, no o_valid, counter unchanged. side_en=2 -> a single sell message with order ref 1.
4. Pulse i_flush during buy word 3 -> the buy completes (9 words), no sell message, o_ready=1 next cycle, next quote gets ref 2.
5. ORDER_ID_W=4, ORDER_ID_BASE=15 -> the first message has ref 15, the second has ref 0 (wrap).
6. Assert i_rst_n low at buy word 5 -> o_valid=0 immediately. After release, a fresh quote starts at word0 with ref=ORDER_ID_BASE. With ENCODER_INT_TS_EN, the captured timestamp equals cycles since reset times TS_INC.

Source files
------------

// File: rtl/itch_order_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : itch_order_encoder
//  Purpose  : Serialises one accepted quote into ITCH "A" (Add Order)
//             messages, buy then sell, on a REG_WIDTH-bit valid/ready/last
//             stream.
//  Options  : ENCODER_INT_TS_EN - capture an internal free-running timestamp
//             instead of i_timestamp.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module itch_order_encoder #(
    parameter int          REG_WIDTH     = 32,
    parameter int          ORDER_ID_W    = 64,
    parameter logic [63:0] ORDER_ID_BASE = 64'd1,
    parameter logic [47:0] TS_INC        = 48'd1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [1:0]           i_stock_symbol,
    input  logic [1:0]           i_side_en,
    input  logic [31:0]          i_buy_price,
    input  logic [31:0]          i_sell_price,
    input  logic [31:0]          i_quantity,
    input  logic [15:0]          i_locate_code,
    input  logic [15:0]          i_tracking_number,
    input  logic [47:0]          i_timestamp,
    input  logic                 i_flush,
    output logic [REG_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_last,
    input  logic                 i_ready
);

    localparam int c_BPW       = REG_WIDTH / 8;
    localparam int c_NUM_WORDS = (36 + c_BPW - 1) / c_BPW;
    localparam int c_IDX_W     = $clog2(c_NUM_WORDS);
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(c_NUM_WORDS - 1);
    localparam logic [ORDER_ID_W-1:0] c_ID_BASE  = ORDER_ID_BASE[ORDER_ID_W-1:0];

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_BUY  = 2'd1,
        EMIT_SELL = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_symbol;
    logic                    r_sell_en;
    logic [31:0]             r_buy_price;
    logic [31:0]             r_sell_price;
    logic [31:0]             r_quantity;
    logic [15:0]             r_locate;
    logic [15:0]             r_tracking;
    logic [47:0]             r_timestamp;
    logic                    r_flush_pend;
    logic [ORDER_ID_W-1:0]   r_order_id;
    logic [c_IDX_W-1:0]      r_word_idx;

    logic                    w_accept;
    logic                    w_hs;
    logic                    w_last_hs;
    logic [47:0]             w_ts_src;
    logic [63:0]             w_sym_ascii;
    logic [63:0]             w_ref64;
    logic [31:0]             w_price;
    logic                    w_is_sell;
    logic [c_NUM_WORDS*REG_WIDTH-1:0] w_msg;
    logic [REG_WIDTH-1:0]    w_word;

`ifdef ENCODER_INT_TS_EN
    logic [47:0] r_ts_ctr;
    logic        w_unused_ts;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_ts_ctr <= '0;
        else          r_ts_ctr <= r_ts_ctr + TS_INC;
    end

    assign w_ts_src    = r_ts_ctr;
    assign w_unused_ts = ^i_timestamp;
`else
    logic [47:0] w_unused_ts_inc;

    assign w_ts_src        = i_timestamp;
    assign w_unused_ts_inc = TS_INC;
`endif

    assign w_accept  = i_valid && o_ready;
    assign w_hs      = o_valid && i_ready;
    assign w_last_hs = w_hs && (r_word_idx == c_LAST_IDX);

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = (r_state == IDLE);
        o_valid     = (r_state != IDLE);
        o_last      = o_valid && (r_word_idx == c_LAST_IDX);
        case (r_state)
            IDLE: begin
                if (w_accept && (i_side_en != 2'b00))
                    w_state_nxt = i_side_en[0] ? EMIT_BUY : EMIT_SELL;
            end
            EMIT_BUY: begin
                // A flush arriving on the final buy handshake still cancels the sell.
                if (w_last_hs)
                    w_state_nxt = (r_sell_en && !(r_flush_pend || i_flush)) ? EMIT_SELL : IDLE;
            end
            EMIT_SELL: begin
                if (w_last_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_symbol     <= '0;
            r_sell_en    <= 1'b0;
            r_buy_price  <= '0;
            r_sell_price <= '0;
            r_quantity   <= '0;
            r_locate     <= '0;
            r_tracking   <= '0;
            r_timestamp  <= '0;
            r_flush_pend <= 1'b0;
            r_order_id   <= c_ID_BASE;
            r_word_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_symbol     <= i_stock_symbol;
                r_sell_en    <= i_side_en[1];
                r_buy_price  <= i_buy_price;
                r_sell_price <= i_sell_price;
                r_quantity   <= i_quantity;
                r_locate     <= i_locate_code;
                r_tracking   <= i_tracking_number;
                r_timestamp  <= w_ts_src;
            end
            if (w_state_nxt == IDLE)
                r_flush_pend <= 1'b0;
            else if ((r_state == EMIT_BUY) && i_flush)
                r_flush_pend <= 1'b1;
            if (w_hs)
                r_word_idx <= (r_word_idx == c_LAST_IDX) ? '0 : r_word_idx + c_IDX_W'(1);
            if (w_last_hs)
                r_order_id <= r_order_id + ORDER_ID_W'(1);
        end
    end

    always_comb begin
        w_sym_ascii = "AAPL    ";
        case (r_symbol)
            2'd0:    w_sym_ascii = "AAPL    ";
            2'd1:    w_sym_ascii = "AMZN    ";
            2'd2:    w_sym_ascii = "GOOGL   ";
            default: w_sym_ascii = "MSFT    ";
        endcase
    end

    assign w_is_sell = (r_state == EMIT_SELL);
    assign w_price   = w_is_sell ? r_sell_price : r_buy_price;
    assign w_ref64   = 64'(r_order_id);

    // Byte n of the message lives at w_msg[8n+7:8n]; fields are big-endian.
    always_comb begin
        w_msg        = '0;
        w_msg[7:0]   = 8'h41;
        for (int i = 0; i < 2; i++) begin
            w_msg[8*(1+i) +: 8] = r_locate[8*(1-i) +: 8];
            w_msg[8*(3+i) +: 8] = r_tracking[8*(1-i) +: 8];
        end
        for (int i = 0; i < 6; i++)
            w_msg[8*(5+i) +: 8] = r_timestamp[8*(5-i) +: 8];
        for (int i = 0; i < 8; i++) begin
            w_msg[8*(11+i) +: 8] = w_ref64[8*(7-i) +: 8];
            w_msg[8*(24+i) +: 8] = w_sym_ascii[8*(7-i) +: 8];
        end
        w_msg[8*19 +: 8] = w_is_sell ? 8'h53 : 8'h42;
        for (int i = 0; i < 4; i++) begin
            w_msg[8*(20+i) +: 8] = r_quantity[8*(3-i) +: 8];
            w_msg[8*(32+i) +: 8] = w_price[8*(3-i) +: 8];
        end
    end

    always_comb begin
        w_word = '0;
        for (int k = 0; k < c_NUM_WORDS; k++)
            if (r_word_idx == c_IDX_W'(k))
                w_word = w_msg[k*REG_WIDTH +: REG_WIDTH];
    end

    assign o_data = o_valid ? w_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_itch_order_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_itch_order_encoder
//  Purpose  : Scoreboard bench for itch_order_encoder: directed quotes then
//             randomised quotes, stalls and flushes against a byte-list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_itch_order_encoder;

    localparam int          TB_RW   = 32;
    localparam int          TB_BPW  = TB_RW / 8;
    localparam int          TB_NW   = (36 + TB_BPW - 1) / TB_BPW;
    localparam int          TB_OIW  = 4;
    localparam logic [63:0] TB_BASE = 64'd15;
    localparam logic [47:0] TB_TSI  = 48'd3;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [1:0]       i_stock_symbol;
    logic [1:0]       i_side_en;
    logic [31:0]      i_buy_price;
    logic [31:0]      i_sell_price;
    logic [31:0]      i_quantity;
    logic [15:0]      i_locate_code;
    logic [15:0]      i_tracking_number;
    logic [47:0]      i_timestamp;
    logic             i_flush;
    logic [TB_RW-1:0] o_data;
    logic             o_valid;
    logic             o_last;
    logic             i_ready;

    typedef struct packed {
        logic [TB_RW-1:0] data;
        logic             last;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mb[$];
    logic [63:0] model_ref;
    bit          rdy_random;
    int          checks = 0;
    int          errors = 0;

    itch_order_encoder #(
        .REG_WIDTH     (TB_RW),
        .ORDER_ID_W    (TB_OIW),
        .ORDER_ID_BASE (TB_BASE),
        .TS_INC        (TB_TSI)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_stock_symbol    (i_stock_symbol),
        .i_side_en         (i_side_en),
        .i_buy_price       (i_buy_price),
        .i_sell_price      (i_sell_price),
        .i_quantity        (i_quantity),
        .i_locate_code     (i_locate_code),
        .i_tracking_number (i_tracking_number),
        .i_timestamp       (i_timestamp),
        .i_flush           (i_flush),
        .o_data            (o_data),
        .o_valid           (o_valid),
        .o_last            (o_last),
        .i_ready           (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

`ifdef ENCODER_INT_TS_EN
    longint tb_cyc;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) tb_cyc <= 0;
        else          tb_cyc <= tb_cyc + 1;
    end
`endif

    // ---------------- reference model ----------------
    function automatic void add_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mb.push_back(v[8*i +: 8]);
    endfunction

    function automatic void model_msg(input bit sell, input logic [1:0] sym,
                                      input logic [31:0] qty, input logic [31:0] price,
                                      input logic [15:0] loc, input logic [15:0] trk,
                                      input logic [47:0] ts);
        logic [63:0] names [4];
        int nw;
        names = '{"AAPL    ", "AMZN    ", "GOOGL   ", "MSFT    "};
        mb.delete();
        add_be(64'h41, 1);
        add_be(64'(loc), 2);
        add_be(64'(trk), 2);
        add_be(64'(ts), 6);
        add_be(model_ref, 8);
        add_be(sell ? 64'h53 : 64'h42, 1);
        add_be(64'(qty), 4);
        add_be(names[sym], 8);
        add_be(64'(price), 4);
        while (mb.size() % TB_BPW != 0) mb.push_back(8'h00);
        nw = mb.size() / TB_BPW;
        for (int k = 0; k < nw; k++) begin
            exp_t e;
            e.data = '0;
            for (int j = 0; j < TB_BPW; j++) e.data[8*j +: 8] = mb[k*TB_BPW + j];
            e.last = (k == nw - 1);
            exp_q.push_back(e);
        end
        model_ref = (model_ref + 64'd1) % (64'd1 << TB_OIW);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            checks++;
            if (o_valid !== (exp_q.size() != 0) || o_ready !== (exp_q.size() == 0)) begin
                errors++;
                $display("FAIL handshake: o_valid=%0b o_ready=%0b, required o_valid=%0b o_ready=%0b",
                         o_valid, o_ready, exp_q.size() != 0, exp_q.size() == 0);
            end
            if (o_valid === 1'b1 && exp_q.size() != 0) begin
                checks++;
                if (o_data !== exp_q[0].data || o_last !== exp_q[0].last) begin
                    errors++;
                    $display("FAIL word: data=%h last=%0b, required data=%h last=%0b",
                             o_data, o_last, exp_q[0].data, exp_q[0].last);
                end
                if (i_ready) void'(exp_q.pop_front());
            end else if (o_valid === 1'b0) begin
                checks++;
                if (o_last !== 1'b0 || o_data !== '0) begin
                    errors++;
                    $display("FAIL idle_out: data=%h last=%0b, required data=0 last=0", o_data, o_last);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        i_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic send_quote(input logic [1:0] sym, input logic [1:0] side,
                              input logic [31:0] qty, input logic [31:0] bp,
                              input logic [31:0] sp, input logic [15:0] loc,
                              input logic [15:0] trk, input logic [47:0] ts,
                              input int flush_at);
        int n;
        logic [47:0] ts_exp;
        i_stock_symbol    = sym;
        i_side_en         = side;
        i_quantity        = qty;
        i_buy_price       = bp;
        i_sell_price      = sp;
        i_locate_code     = loc;
        i_tracking_number = trk;
        i_timestamp       = ts;
        i_valid           = 1'b1;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: o_ready=%0b, required 1", o_ready);
                i_valid = 1'b0;
                return;
            end
            tick();
        end
        tick();
        i_valid = 1'b0;
`ifdef ENCODER_INT_TS_EN
        ts_exp = 48'((tb_cyc - 1) * longint'(TB_TSI));
`else
        ts_exp = ts;
`endif
        if (side[0]) model_msg(1'b0, sym, qty, bp, loc, trk, ts_exp);
        if (side[1] && !(side[0] && flush_at > 0)) model_msg(1'b1, sym, qty, sp, loc, trk, ts_exp);
        if (flush_at > 0) begin
            repeat (flush_at - 1) tick();
            i_flush = 1'b1;
            tick();
            i_flush = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            tick();
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] r64;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        i_stock_symbol = '0; i_side_en = '0; i_buy_price = '0; i_sell_price = '0;
        i_quantity = '0; i_locate_code = '0; i_tracking_number = '0; i_timestamp = '0;
        rdy_random = 1'b0;
        model_ref  = TB_BASE;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_last",  64'(o_last),  64'd0);
        chk("reset_data",  64'(o_data),  64'd0);
        chk("reset_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Buy then sell, refs wrap from 15 to 0
        send_quote(2'd0, 2'd3, 32'd100, 32'h2710, 32'h2774, 16'h0001, 16'h0002, 48'h1234, 0);
        wait_drain();

        // Three-cycle downstream stall while word 4 is presented
        send_quote(2'd2, 2'd3, 32'd250, 32'h1111, 32'h2222, 16'h00AB, 16'h0042, 48'hABCDEF012345, 0);
        repeat (4) tick();
        i_ready = 1'b0;
        repeat (3) begin @(posedge i_clk); #1; end
        i_ready = 1'b1;
        wait_drain();

        // No side enabled, then sell only
        send_quote(2'd3, 2'd0, 32'd5, 32'd6, 32'd7, 16'd8, 16'd9, 48'd10, 0);
        tick();
        send_quote(2'd1, 2'd2, 32'd77, 32'h0BAD, 32'h0F00D, 16'h1234, 16'h5678, 48'h9, 0);
        wait_drain();

        // Flush during buy word 3 skips the sell
        send_quote(2'd2, 2'd3, 32'd9, 32'd1, 32'd2, 16'd3, 16'd4, 48'd5, 4);
        wait_drain();
        send_quote(2'd0, 2'd1, 32'd1, 32'd2, 32'd3, 16'd4, 16'd5, 48'd6, 0);
        wait_drain();

        // Asynchronous reset in the middle of a buy message
        send_quote(2'd3, 2'd3, 32'd42, 32'd43, 32'd44, 16'd45, 16'd46, 48'd47, 0);
        repeat (5) tick();
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_last",  64'(o_last),  64'd0);
        chk("midrst_ready", 64'(o_ready), 64'd1);
        exp_q.delete();
        model_ref = TB_BASE;
        repeat (2) tick();
        i_rst_n = 1'b1;
        send_quote(2'd1, 2'd3, 32'd500, 32'h3000, 32'h3100, 16'h0007, 16'h0008, 48'h777, 0);
        wait_drain();

        // Randomised quotes, stalls and flushes
        rdy_random = 1'b1;
        for (int q = 0; q < 40; q++) begin
            r64 = {$urandom(), $urandom()};
            send_quote(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom(),
                       $urandom(), $urandom(), 16'($urandom()), 16'($urandom()), r64[47:0],
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TB_NW)) : 0);
            if ($urandom_range(0, 1) == 0) wait_drain();
        end
        wait_drain();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
